irq_priority_ctrl: RTL



---
 rtl/irq_ctrl_pkg.sv | 35 +++
 rtl/irq_pri_encoder16.sv | 20 ++
 rtl/irq_priority_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared constants, the controller state type and the priority helper used by
// the 16-source interrupt controller.
//   NUM_SRC      number of request sources (16)
//   ID_W         width of a source index (4)
//   irq_state_e  controller states IDLE / PRESENT / HOLD
//   highest_idx  index of the most significant set bit (0 when none set)
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

  localparam int NUM_SRC = 16;
  localparam int ID_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } irq_state_e;

  // Ascending scan, so the last (highest) set bit found overwrites lower ones.
  function automatic logic [ID_W-1:0] highest_idx(input logic [NUM_SRC-1:0] vec);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vec[i]) begin
        idx = ID_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_pri_encoder16.sv
// -----------------------------------------------------------------------------
// irq_pri_encoder16
// Purely combinational 16-to-4 priority encoder; bit 15 has highest priority.
// Ports:
//   req_in   in  16  request vector
//   idx_out  out  4  index of highest set bit (0 when none set)
//   any_out  out  1  at least one request bit set
// -----------------------------------------------------------------------------
module irq_pri_encoder16
  import irq_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_in,
  output logic [ID_W-1:0]    idx_out,
  output logic               any_out
);

  assign idx_out = highest_idx(req_in);
  assign any_out = |req_in;

endmodule

// File: rtl/irq_priority_ctrl.sv
// -----------------------------------------------------------------------------
// irq_priority_ctrl
// Sixteen-source interrupt controller: latches requests into a pending
// register, masks them and presents the highest-priority eligible source over
// a valid/ack handshake, with an optional acknowledge timeout.
// Parameters:
//   TIMEOUT_CYCLES  cycles irq_valid may stay high without ack (0 = no timeout)
//   CNT_W           timeout counter width, must hold TIMEOUT_CYCLES
// Ports:
//   clk          in   1  clock, rising edge
//   rst_n        in   1  synchronous active-low reset
//   enable       in   1  allows new presentations
//   irq_in       in  16  request lines, bit 15 highest priority
//   mask_in      in  16  1 = source masked (still latched, never presented)
//   irq_ack      in   1  consumer accepts presented id
//   irq_valid    out  1  id presented
//   irq_id       out  4  presented source index
//   pending      out 16  latched pending bits
//   timeout_err  out  1  one-cycle pulse on ack timeout
// Build option:
//   IRQ_EDGE_DETECT_EN  defined: rising-edge capture; undefined: level capture
// -----------------------------------------------------------------------------
module irq_priority_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] mask_in,
  input  logic               irq_ack,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               timeout_err
);

  localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);
  // Counter starts at 0 on the first presented cycle, so the last one is T-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  irq_state_e         state_r, state_nxt_s;
  logic [NUM_SRC-1:0] pending_r, pending_nxt_s;
  logic [ID_W-1:0]    id_r, id_nxt_s;
  logic               valid_r, valid_nxt_s;
  logic               terr_r, terr_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;

  logic [NUM_SRC-1:0] capture_s;
  logic [NUM_SRC-1:0] clear_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic [ID_W-1:0]    enc_id_s;
  logic               enc_any_s;

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] irq_q_r;

  // Request history for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q_r <= {NUM_SRC{1'b0}};
    end else begin
      irq_q_r <= irq_in;
    end
  end

  assign capture_s = irq_in & ~irq_q_r;
`else
  assign capture_s = irq_in;
`endif

  assign eligible_s = pending_r & ~mask_in;

  irq_pri_encoder16 u_enc (
    .req_in  (eligible_s),
    .idx_out (enc_id_s),
    .any_out (enc_any_s)
  );

  // Next-state, presentation and pending-update logic.
  always_comb begin
    state_nxt_s = state_r;
    id_nxt_s    = id_r;
    valid_nxt_s = valid_r;
    terr_nxt_s  = 1'b0;
    cnt_nxt_s   = cnt_r;
    clear_s     = {NUM_SRC{1'b0}};
    case (state_r)
      IDLE: begin
        if (enable && enc_any_s) begin
          state_nxt_s = PRESENT;
          id_nxt_s    = enc_id_s;
          valid_nxt_s = 1'b1;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
          valid_nxt_s = 1'b0;
        end
      end
      PRESENT: begin
        // irq_id is frozen here; mask/enable/pending changes do not disturb it.
        if (irq_ack) begin
          clear_s     = {{(NUM_SRC-1){1'b0}}, 1'b1} << id_r;
          state_nxt_s = HOLD;
          valid_nxt_s = 1'b0;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (TO_EN && (cnt_r == TO_LAST)) begin
          terr_nxt_s  = 1'b1;
          state_nxt_s = HOLD;
          valid_nxt_s = 1'b0;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s   = TO_EN ? (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_r;
        end
      end
      HOLD: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
    // A capture in the same cycle as the acknowledge clear keeps the bit set.
    pending_nxt_s = (pending_r & ~clear_s) | capture_s;
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pending_r <= {NUM_SRC{1'b0}};
      id_r      <= {ID_W{1'b0}};
      valid_r   <= 1'b0;
      terr_r    <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
      id_r      <= id_nxt_s;
      valid_r   <= valid_nxt_s;
      terr_r    <= terr_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  assign irq_valid   = valid_r;
  assign irq_id      = id_r;
  assign pending     = pending_r;
  assign timeout_err = terr_r;

endmodule
